// File: rtl/ibex_rf_writeback.sv
// Writeback stage feeding the register file write port: retires EX results directly and
// formats the single outstanding LSU load response before writing it back.
module ibex_rf_writeback #(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_rd_i,
  input  logic                 ex_rf_we_i,
  input  logic [DataWidth-1:0] ex_result_i,
  input  logic                 ex_load_i,
  input  logic [1:0]           ex_load_type_i,
  input  logic                 ex_load_sext_i,
  input  logic [1:0]           ex_addr_lsb_i,
  input  logic                 lsu_rvalid_i,
  input  logic [31:0]          lsu_rdata_i,
  input  logic                 lsu_err_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 load_pending_o,
  output logic [4:0]           load_rd_o,
  output logic                 load_err_o,
  output logic                 illegal_rd_o
);

  localparam int unsigned AddrW = 5;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [AddrW-1:0]     load_rd_q;
  logic [1:0]           load_type_q;
  logic                 load_sext_q;
  logic [1:0]           load_lsb_q;
  logic                 capture;

  logic                 wr_req;
  logic [AddrW-1:0]     wr_addr;
  logic [DataWidth-1:0] wr_data;
  logic                 rf_we_d, rf_we_q;
  logic [AddrW-1:0]     rf_waddr_q;
  logic [DataWidth-1:0] rf_wdata_q;
  logic                 load_err_d, load_err_q;
  logic                 illegal_d, illegal_q;

  logic [15:0]          half_w;
  logic [7:0]           byte_w;
  logic [31:0]          fmt_data;

  // Select the addressed lane of the returning word and extend it
  always_comb begin
    half_w   = load_lsb_q[1] ? lsu_rdata_i[31:16] : lsu_rdata_i[15:0];
    byte_w   = lsu_rdata_i[{load_lsb_q, 3'b000} +: 8];
    fmt_data = lsu_rdata_i;
    case (load_type_q)
      2'b01:   fmt_data = {{16{load_sext_q & half_w[15]}}, half_w};
      2'b10:   fmt_data = {{24{load_sext_q & byte_w[7]}}, byte_w};
      default: fmt_data = lsu_rdata_i;
    endcase
  end

  // Next-state and write-request decode
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    wr_req     = 1'b0;
    wr_addr    = ex_rd_i;
    wr_data    = ex_result_i;
    load_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          if (ex_load_i) begin
            capture = 1'b1;
            state_d = WAIT_RSP;
          end else if (ex_rf_we_i) begin
            wr_req = 1'b1;
          end
        end
      end
      WAIT_RSP: begin
        if (lsu_rvalid_i) begin
          state_d = IDLE;
          if (lsu_err_i) begin
            load_err_d = 1'b1;
          end else begin
            wr_req  = 1'b1;
            wr_addr = load_rd_q;
            wr_data = DataWidth'(fmt_data);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // x0 writes vanish silently; RV32E upper registers flag an illegal destination
    illegal_d = wr_req & RV32E & wr_addr[4];
    rf_we_d   = wr_req & (wr_addr != '0) & ~illegal_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      load_rd_q   <= '0;
      load_type_q <= '0;
      load_sext_q <= 1'b0;
      load_lsb_q  <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      load_err_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      load_err_q <= load_err_d;
      illegal_q  <= illegal_d;
      if (capture) begin
        load_rd_q   <= ex_rd_i;
        load_type_q <= ex_load_type_i;
        load_sext_q <= ex_load_sext_i;
        load_lsb_q  <= ex_addr_lsb_i;
      end
      if (rf_we_d) begin
        rf_waddr_q <= wr_addr;
        rf_wdata_q <= wr_data;
      end
    end
  end

  assign ex_ready_o     = (state_q == IDLE);
  assign load_pending_o = (state_q == WAIT_RSP);
  assign load_rd_o      = load_rd_q;
  assign rf_we_o        = rf_we_q;
  assign rf_waddr_o     = rf_waddr_q;
  assign rf_wdata_o     = rf_wdata_q;
  assign load_err_o     = load_err_q;
  assign illegal_rd_o   = illegal_q;

endmodule
